// File: rtl/dlx_ctrl_decode.sv
// dlx_ctrl_decode: multicycle DLX fetch/decode/execute sequencer driving an external ALU; DLX_CTRL_PERF_EN adds cycle/instret counters
module dlx_ctrl_decode #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [4:0]  LINK_REG = 5'd31
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [4:0]  rf_raddr1,
    output logic [4:0]  rf_raddr2,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        EX,
    output logic [4:0]  I,
    output logic [31:0] op1,
    output logic [31:0] op2,
    input  logic [31:0] res1,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        illegal
`ifdef DLX_CTRL_PERF_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
    state_t state, state_nx;
    logic [31:0] pc, instr, st_data, ld_data, simm, zimm, joff;
    logic [5:0]  opc, fn;
    logic [4:0]  alu_i;
    logic        legal, is_r, is_zx, is_br, is_j, is_jal, is_lw, is_sw, wr;

    assign opc    = instr[31:26];
    assign fn     = instr[5:0];
    assign simm   = {{16{instr[15]}}, instr[15:0]};
    assign zimm   = {16'h0, instr[15:0]};
    assign joff   = {{6{instr[25]}}, instr[25:0]};
    assign is_r   = opc == 6'h00;
    assign is_zx  = opc inside {6'h0C, 6'h0D, 6'h0E, 6'h0F};
    assign is_br  = opc inside {6'h04, 6'h05};
    assign is_j   = opc inside {6'h02, 6'h03};
    assign is_jal = opc == 6'h03;
    assign is_lw  = opc == 6'h23;
    assign is_sw  = opc == 6'h2B;
    assign wr     = !(is_br || is_sw || (is_j && !is_jal));

    assign imem_req   = state == FETCH;
    assign imem_addr  = pc;
    assign rf_raddr1  = instr[25:21];
    assign rf_raddr2  = instr[20:16];
    assign EX         = state == EXEC;
    assign dmem_req   = state == MEM;
    assign dmem_we    = state == MEM && is_sw;
    assign dmem_addr  = res1;
    assign dmem_wdata = st_data;
    assign illegal    = state == TRAP;
    assign rf_waddr   = is_jal ? LINK_REG : is_r ? instr[15:11] : instr[20:16];
    assign rf_wdata   = is_lw ? ld_data : res1;
    assign rf_we      = state == WB && wr && rf_waddr != 5'd0;

    // instruction decode: ALU opcode and legality from the latched instruction
    always_comb begin
        legal = 1'b1;
        alu_i = 5'd0;
        if (is_r) begin
            case (fn)
                6'h04:        alu_i = 5'd6;
                6'h06:        alu_i = 5'd7;
                6'h07:        alu_i = 5'd14;
                6'h20, 6'h21: alu_i = 5'd1;
                6'h22, 6'h23: alu_i = 5'd2;
                6'h24:        alu_i = 5'd3;
                6'h25:        alu_i = 5'd4;
                6'h26:        alu_i = 5'd5;
                6'h28:        alu_i = 5'd10;
                6'h29:        alu_i = 5'd13;
                6'h2A:        alu_i = 5'd12;
                6'h2C:        alu_i = 5'd11;
                default:      legal = 1'b0;
            endcase
        end else begin
            case (opc)
                6'h08, 6'h09, 6'h23, 6'h2B: alu_i = 5'd1;
                6'h0A, 6'h0B:               alu_i = 5'd2;
                6'h0C:                      alu_i = 5'd3;
                6'h0D:                      alu_i = 5'd4;
                6'h0E:                      alu_i = 5'd5;
                6'h0F:                      alu_i = 5'd0;
                6'h14:                      alu_i = 5'd6;
                6'h16:                      alu_i = 5'd7;
                6'h17:                      alu_i = 5'd14;
                6'h18:                      alu_i = 5'd10;
                6'h19:                      alu_i = 5'd13;
                6'h1A:                      alu_i = 5'd12;
                6'h1C:                      alu_i = 5'd11;
                6'h04:                      alu_i = 5'd16;
                6'h05:                      alu_i = 5'd17;
                6'h02, 6'h03:               alu_i = 5'd15;
                default:                    legal = 1'b0;
            endcase
        end
    end

    // sequencer next state; TRAP only leaves through reset
    always_comb begin
        state_nx = state;
        case (state)
            FETCH:   state_nx = imem_ack ? DECODE : FETCH;
            DECODE:  state_nx = legal ? EXEC : TRAP;
            EXEC:    state_nx = (is_lw || is_sw) ? MEM : WB;
            MEM:     state_nx = dmem_ack ? WB : MEM;
            WB:      state_nx = FETCH;
            default: state_nx = TRAP;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= state_nx;
    end

    // datapath: instruction latch, ALU operands, memory data and pc update
    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= RESET_PC;
            instr   <= 32'h0;
            I       <= 5'd0;
            op1     <= 32'h0;
            op2     <= 32'h0;
            st_data <= 32'h0;
            ld_data <= 32'h0;
        end else begin
            if (state == FETCH && imem_ack) instr <= imem_rdata;
            if (state == DECODE && legal) begin
                I       <= alu_i;
                op1     <= is_j ? pc : rf_rdata1;
                op2     <= is_r ? rf_rdata2 : is_j ? 32'h0 : is_br ? simm + 32'd4 : is_zx ? zimm : simm;
                st_data <= rf_rdata2;
            end
            if (state == MEM && dmem_ack) ld_data <= dmem_rdata;
            if (state == WB) pc <= is_br ? pc + res1 : is_j ? pc + 32'd4 + joff : pc + 32'd4;
        end
    end

`ifdef DLX_CTRL_PERF_EN
    // performance counters; cycle count stops once trapped
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt   <= 32'h0;
            instret_cnt <= 32'h0;
        end else begin
            if (state != TRAP) cycle_cnt <= cycle_cnt + 32'd1;
            if (state == WB) instret_cnt <= instret_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dlx_ctrl_decode.sv
// tb_dlx_ctrl_decode: randomized self-checking bench with an instruction-level reference model
module tb_dlx_ctrl_decode;
    localparam int K_R = 0, K_IS = 1, K_IZ = 2, K_LW = 3, K_SW = 4, K_BR = 5, K_J = 6, K_JAL = 7;

    typedef struct {
        logic [5:0] opc;
        logic [5:0] fn;
        logic [4:0] alu;
        int         kind;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req, imem_ack, rf_we, EX, dmem_req, dmem_we, dmem_ack, illegal;
    logic [31:0] imem_addr, imem_rdata, rf_rdata1, rf_rdata2, rf_wdata, op1, op2;
    logic [31:0] res1, dmem_addr, dmem_wdata, dmem_rdata;
    logic [4:0]  rf_raddr1, rf_raddr2, rf_waddr, I;

    logic [31:0] rf [32] = '{default: 32'h0};
    logic [31:0] mregs [32];
    logic [31:0] mpc;
    int          ex_cnt = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    ent_t        tbl[$];

    always #5 clk = ~clk;

    dlx_ctrl_decode dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .EX(EX), .I(I), .op1(op1), .op2(op2), .res1(res1),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .illegal(illegal)
    );

    function automatic logic [31:0] alu_f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            5'd0:    return b << 16;
            5'd1:    return a + b;
            5'd2:    return a - b;
            5'd3:    return a & b;
            5'd4:    return a | b;
            5'd5:    return a ^ b;
            5'd6:    return a << b[4:0];
            5'd7:    return a >> b[4:0];
            5'd14:   return $unsigned($signed(a) >>> b[4:0]);
            5'd10:   return {31'b0, a == b};
            5'd13:   return {31'b0, a != b};
            5'd12:   return {31'b0, $signed(a) < $signed(b)};
            5'd11:   return {31'b0, $signed(a) <= $signed(b)};
            5'd15:   return a + 32'd4;
            5'd16:   return a == 32'h0 ? b : 32'd4;
            5'd17:   return a != 32'h0 ? b : 32'd4;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];

    // register file and registered ALU seen by the sequencer
    always @(posedge clk) begin
        if (rf_we && rf_waddr != 5'd0) rf[rf_waddr] <= rf_wdata;
        if (EX) begin
            res1   <= alu_f(I, op1, op2);
            ex_cnt <= ex_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic add(input logic [5:0] o, input logic [5:0] f, input logic [4:0] a, input int k);
        ent_t t;
        t.opc = o; t.fn = f; t.alu = a; t.kind = k;
        tbl.push_back(t);
    endtask

    function automatic int idx(input logic [5:0] o, input logic [5:0] f);
        foreach (tbl[i]) if (tbl[i].opc == o && tbl[i].fn == f) return i;
        return 0;
    endfunction

    // one full instruction from a FETCH-state negedge to the next FETCH-state negedge
    task automatic run(input int e, input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rd,
                       input logic [25:0] imm, input int idly, input int ddly);
        logic [31:0] ins, a, b, s, wv, npc, ld;
        logic [4:0]  wa;
        logic        we, cond;
        int          k, ex0;
        k  = tbl[e].kind;
        s  = {{16{imm[15]}}, imm[15:0]};
        ld = $urandom;
        case (k)
            K_R:        ins = {6'h00, ra, rb, rd, 5'h0, tbl[e].fn};
            K_SW:       ins = {tbl[e].opc, ra, rb, imm[15:0]};
            K_BR:       ins = {tbl[e].opc, ra, 5'd0, imm[15:0]};
            K_J, K_JAL: ins = {tbl[e].opc, imm};
            default:    ins = {tbl[e].opc, ra, rd, imm[15:0]};
        endcase
        a  = (k == K_J || k == K_JAL) ? mpc : mregs[ra];
        b  = k == K_R ? mregs[rb] : k == K_IZ ? {16'h0, imm[15:0]} : k == K_BR ? s + 32'd4 : s;
        we = k inside {K_R, K_IS, K_IZ, K_LW, K_JAL};
        wa = k == K_JAL ? 5'd31 : rd;
        wv = k == K_JAL ? mpc + 32'd4 : k == K_LW ? ld : alu_f(tbl[e].alu, a, b);
        we = we && wa != 5'd0;
        cond = tbl[e].opc == 6'h04 ? mregs[ra] == 32'h0 : mregs[ra] != 32'h0;
        npc = k == K_BR ? (cond ? mpc + 32'd4 + s : mpc + 32'd4) :
              (k == K_J || k == K_JAL) ? mpc + 32'd4 + {{6{imm[25]}}, imm} : mpc + 32'd4;
        chk("imem_req", {31'b0, imem_req}, 32'd1);
        chk("imem_addr", imem_addr, mpc);
        repeat (idly) begin
            @(negedge clk);
            chk("imem_hold", {31'b0, imem_req}, 32'd1);
        end
        imem_ack = 1'b1;
        imem_rdata = ins;
        ex0 = ex_cnt;
        @(negedge clk);
        imem_ack = 1'b0;
        imem_rdata = $urandom;
        chk("ex_decode", {31'b0, EX}, 32'd0);
        @(negedge clk);
        chk("ex", {31'b0, EX}, 32'd1);
        chk("alu_I", {27'b0, I}, {27'b0, tbl[e].alu});
        chk("op1", op1, a);
        if (k != K_J && k != K_JAL) chk("op2", op2, b);
        @(negedge clk);
        if (k == K_LW || k == K_SW) begin
            chk("dmem_req", {31'b0, dmem_req}, 32'd1);
            chk("dmem_addr", dmem_addr, a + b);
            chk("dmem_we", {31'b0, dmem_we}, {31'b0, k == K_SW});
            if (k == K_SW) chk("dmem_wdata", dmem_wdata, mregs[rb]);
            repeat (ddly) begin
                @(negedge clk);
                chk("dmem_hold", {31'b0, dmem_req}, 32'd1);
            end
            dmem_ack = 1'b1;
            dmem_rdata = ld;
            @(negedge clk);
            dmem_ack = 1'b0;
            dmem_rdata = $urandom;
        end
        chk("dmem_idle", {31'b0, dmem_req}, 32'd0);
        chk("rf_we", {31'b0, rf_we}, {31'b0, we});
        if (we) begin
            chk("rf_waddr", {27'b0, rf_waddr}, {27'b0, wa});
            chk("rf_wdata", rf_wdata, wv);
            mregs[wa] = wv;
        end
        chk("ex_once", 32'(ex_cnt - ex0), 32'd1);
        mpc = npc;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mpc = 32'h0;
        chk("rst_imem_req", {31'b0, imem_req}, 32'd1);
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_illegal", {31'b0, illegal}, 32'd0);
        chk("rst_ex", {31'b0, EX}, 32'd0);
    endtask

    // illegal instruction must trap: no EX, no further fetches, illegal held
    task automatic trap_case(input logic [31:0] ins);
        int ex0;
        ex0 = ex_cnt;
        imem_ack = 1'b1;
        imem_rdata = ins;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("trap_decode_illegal", {31'b0, illegal}, 32'd0);
        repeat (5) begin
            @(negedge clk);
            chk("trap_illegal", {31'b0, illegal}, 32'd1);
            chk("trap_no_req", {31'b0, imem_req}, 32'd0);
            chk("trap_no_ex", {31'b0, EX}, 32'd0);
        end
        chk("trap_ex_count", 32'(ex_cnt - ex0), 32'd0);
        do_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        add(6'h00, 6'h04, 5'd6, K_R);   add(6'h00, 6'h06, 5'd7, K_R);   add(6'h00, 6'h07, 5'd14, K_R);
        add(6'h00, 6'h20, 5'd1, K_R);   add(6'h00, 6'h21, 5'd1, K_R);   add(6'h00, 6'h22, 5'd2, K_R);
        add(6'h00, 6'h23, 5'd2, K_R);   add(6'h00, 6'h24, 5'd3, K_R);   add(6'h00, 6'h25, 5'd4, K_R);
        add(6'h00, 6'h26, 5'd5, K_R);   add(6'h00, 6'h28, 5'd10, K_R);  add(6'h00, 6'h29, 5'd13, K_R);
        add(6'h00, 6'h2A, 5'd12, K_R);  add(6'h00, 6'h2C, 5'd11, K_R);
        add(6'h08, 6'h00, 5'd1, K_IS);  add(6'h09, 6'h00, 5'd1, K_IS);  add(6'h0A, 6'h00, 5'd2, K_IS);
        add(6'h0B, 6'h00, 5'd2, K_IS);  add(6'h14, 6'h00, 5'd6, K_IS);  add(6'h16, 6'h00, 5'd7, K_IS);
        add(6'h17, 6'h00, 5'd14, K_IS); add(6'h18, 6'h00, 5'd10, K_IS); add(6'h19, 6'h00, 5'd13, K_IS);
        add(6'h1A, 6'h00, 5'd12, K_IS); add(6'h1C, 6'h00, 5'd11, K_IS);
        add(6'h0C, 6'h00, 5'd3, K_IZ);  add(6'h0D, 6'h00, 5'd4, K_IZ);  add(6'h0E, 6'h00, 5'd5, K_IZ);
        add(6'h0F, 6'h00, 5'd0, K_IZ);
        add(6'h23, 6'h00, 5'd1, K_LW);  add(6'h2B, 6'h00, 5'd1, K_SW);
        add(6'h04, 6'h00, 5'd16, K_BR); add(6'h05, 6'h00, 5'd17, K_BR);
        add(6'h02, 6'h00, 5'd15, K_J);  add(6'h03, 6'h00, 5'd15, K_JAL);
        foreach (mregs[i]) mregs[i] = 32'h0;
        mpc = 32'h0;
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_imem_req", {31'b0, imem_req}, 32'd1);
        chk("reset_imem_addr", imem_addr, 32'h0);
        chk("reset_ex", {31'b0, EX}, 32'd0);
        chk("reset_rf_we", {31'b0, rf_we}, 32'd0);
        chk("reset_illegal", {31'b0, illegal}, 32'd0);
        chk("reset_dmem_req", {31'b0, dmem_req}, 32'd0);
        chk("reset_I", {27'b0, I}, 32'd0);
        chk("reset_op1", op1, 32'h0);
        chk("reset_op2", op2, 32'h0);
        run(idx(6'h08, 6'h00), 5'd0, 5'd0, 5'd1, 26'd5, 0, 0);
        chk("addi_next_pc", imem_addr, 32'h4);
        run(idx(6'h08, 6'h00), 5'd1, 5'd0, 5'd1, 26'hFB, 1, 0);
        run(idx(6'h08, 6'h00), 5'd0, 5'd0, 5'd4, 26'd7, 0, 0);
        run(idx(6'h08, 6'h00), 5'd0, 5'd0, 5'd5, 26'hFFFF, 2, 0);
        run(idx(6'h04, 6'h00), 5'd2, 5'd0, 5'd0, 26'd8, 0, 0);
        chk("beqz_taken_pc", imem_addr, 32'h1C);
        run(idx(6'h08, 6'h00), 5'd0, 5'd0, 5'd2, 26'd3, 0, 0);
        run(idx(6'h04, 6'h00), 5'd2, 5'd0, 5'd0, 26'd8, 0, 0);
        chk("beqz_not_taken_pc", imem_addr, 32'h24);
        run(idx(6'h23, 6'h00), 5'd1, 5'd0, 5'd3, 26'd4, 0, 2);
        run(idx(6'h2B, 6'h00), 5'd1, 5'd4, 5'd0, 26'd8, 1, 1);
        run(idx(6'h08, 6'h00), 5'd1, 5'd0, 5'd0, 26'd1, 0, 0);
        run(idx(6'h05, 6'h00), 5'd5, 5'd0, 5'd0, 26'hFFF0, 0, 0);
        run(idx(6'h03, 6'h00), 5'd0, 5'd0, 5'd0, 26'h3FF_FFF8, 0, 0);
        run(idx(6'h02, 6'h00), 5'd0, 5'd0, 5'd0, 26'd64, 0, 0);
        run(idx(6'h00, 6'h2A), 5'd5, 5'd4, 5'd6, 26'd0, 0, 0);
        run(idx(6'h17, 6'h00), 5'd5, 5'd0, 5'd7, 26'd4, 0, 0);
        run(idx(6'h0F, 6'h00), 5'd0, 5'd0, 5'd7, 26'h8001, 0, 0);
        for (int n = 0; n < 200; n++)
            run($urandom_range(0, tbl.size() - 1), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 26'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
        trap_case({6'h00, 20'h12345, 6'h3F});
        run(idx(6'h08, 6'h00), 5'd0, 5'd0, 5'd1, 26'h100, 0, 0);
        trap_case({6'h3F, 26'h0});
        chk("trap_refetch_pc", imem_addr, 32'h0);
        imem_ack = 1'b1;
        imem_rdata = {6'h23, 5'd1, 5'd3, 16'h4};
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mem_rst_req_before", {31'b0, dmem_req}, 32'd1);
        rst = 1'b1;
        dmem_ack = 1'b1;
        dmem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        rst = 1'b0;
        dmem_ack = 1'b0;
        mpc = 32'h0;
        chk("mem_rst_dmem_req", {31'b0, dmem_req}, 32'd0);
        chk("mem_rst_imem_req", {31'b0, imem_req}, 32'd1);
        chk("mem_rst_imem_addr", imem_addr, 32'h0);
        chk("mem_rst_rf_we", {31'b0, rf_we}, 32'd0);
        @(negedge clk);
        chk("mem_rst_rf_we_after", {31'b0, rf_we}, 32'd0);
        run(idx(6'h00, 6'h20), 5'd3, 5'd1, 5'd8, 26'd0, 0, 0);
        run(idx(6'h23, 6'h00), 5'd8, 5'd0, 5'd9, 26'hFFFC, 1, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
